instruction_fetch_queue: RTL and testbench

INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

---
 rtl/fetch_pkg.sv | 16 +
 rtl/instruction_fetch_queue_if.sv | 37 +++
 rtl/fetch_fifo.sv | 54 +++++
 rtl/instruction_fetch_queue.sv | 111 +++++++++++
 tb/tb_instruction_fetch_queue.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, depth default and the fetched-pair record
// Purpose: defaults for the fetch queue slice and the payload it stores.
// Contents: PC_WIDTH_DEF, INSTR_WIDTH_DEF, DEPTH_DEF, fetch_pair_t {pc, instr1, instr2}.
package fetch_pkg;

  localparam int PC_WIDTH_DEF    = 11;
  localparam int INSTR_WIDTH_DEF = 32;
  localparam int DEPTH_DEF       = 4;

  typedef struct packed {
    logic [PC_WIDTH_DEF-1:0]    pc;
    logic [INSTR_WIDTH_DEF-1:0] instr1;
    logic [INSTR_WIDTH_DEF-1:0] instr2;
  } fetch_pair_t;

endpackage

// File: rtl/instruction_fetch_queue_if.sv
// rtl/instruction_fetch_queue_if.sv - instruction memory bus and output pair stream
// Purpose: bundles the imem request/response and the consumer handshake.
// Modports: master = fetch queue (drives imem_req/addr and out_*),
//           slave  = memory + consumer (drives imem_rdata1/2 and out_ready).
interface instruction_fetch_queue_if
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH    = PC_WIDTH_DEF,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF
);

  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata1;
  logic [INSTR_WIDTH-1:0] imem_rdata2;
  logic                   out_valid;
  logic                   out_ready;
  logic [INSTR_WIDTH-1:0] out_instr1;
  logic [INSTR_WIDTH-1:0] out_instr2;
  logic [PC_WIDTH-1:0]    out_pc;
  logic [PC_WIDTH-1:0]    out_pc_next;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata1, imem_rdata2,
    output out_valid, out_instr1, out_instr2, out_pc, out_pc_next,
    input  out_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata1, imem_rdata2,
    input  out_valid, out_instr1, out_instr2, out_pc, out_pc_next,
    output out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular queue of fetched instruction pairs
// Purpose: DEPTH-entry FIFO with synchronous flush and an occupancy count.
// Ports: clk, rst_n (async, active-low), flush, push/push_data, pop,
//        head (entry at the read pointer), count (0..DEPTH).
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH     = DEPTH_DEF,
  parameter type payload_t = fetch_pair_t,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  input  logic     push,
  input  payload_t push_data,
  input  logic     pop,
  output payload_t head,
  output logic [AW:0] count
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  payload_t      mem [DEPTH];
  logic          do_pop;
  logic          do_push;

  assign do_pop  = pop && (count != '0);
  // A push into a full queue is only legal when the head leaves at the same edge.
  assign do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset: nothing reads it while count is zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instruction_fetch_queue.sv
// rtl/instruction_fetch_queue.sv - paired instruction fetch with redirect and output queue
// Purpose: issues pair fetches (PC, PC+1), queues responses, presents them in order.
// Ports: clk, reset (async, active-low), fetch_enable, redirect_valid/redirect_pc,
//        bus (master): imem_req/imem_addr/imem_rdata1/2 and out_valid/out_ready/out_*.
module instruction_fetch_queue
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH    = PC_WIDTH_DEF,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_enable,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  instruction_fetch_queue_if.master bus
);

  localparam int AW = $clog2(DEPTH);

  // Same layout as fetch_pair_t, sized to this instance's widths.
  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr1;
    logic [INSTR_WIDTH-1:0] instr2;
  } pair_t;

  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] flight_pc;
  logic                in_flight;
  logic [AW:0]         count;
  logic                head_valid;
  logic                pop;
  logic                push;
  logic                issue;
  pair_t               head;
  pair_t               push_data;
  pair_t               shown;
  pair_t               shown_q;
  logic [PC_WIDTH-1:0] pc_next;
  logic [PC_WIDTH-1:0] pc_next_q;

  assign head_valid = (count != '0);
  // A redirect discards both the pop and the arriving response.
  assign pop  = head_valid && bus.out_ready && !redirect_valid;
  assign push = in_flight && !redirect_valid;

  // Credit check counts the slot freed by this cycle's pop, so a full queue
  // being drained keeps fetching back to back.
  assign issue = reset && fetch_enable && !redirect_valid &&
                 ((int'(count) + int'(in_flight) - int'(pop)) < DEPTH);

  assign push_data = '{pc: flight_pc, instr1: bus.imem_rdata1, instr2: bus.imem_rdata2};

  fetch_fifo #(
    .DEPTH     (DEPTH),
    .payload_t (pair_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc  <= RESET_PC;
      flight_pc <= '0;
      in_flight <= 1'b0;
    end else if (redirect_valid) begin
      // Clearing in_flight is the kill: the pending response is never pushed.
      fetch_pc  <= redirect_pc;
      in_flight <= 1'b0;
    end else begin
      in_flight <= issue;
      if (issue) begin
        flight_pc <= fetch_pc;
        fetch_pc  <= fetch_pc + PC_WIDTH'(2);
      end
    end
  end

  // While empty the outputs keep showing the last presented pair.
  assign shown   = head_valid ? head : shown_q;
  assign pc_next = head_valid ? head.pc + PC_WIDTH'(2) : pc_next_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shown_q   <= '0;
      pc_next_q <= '0;
    end else begin
      shown_q   <= shown;
      pc_next_q <= pc_next;
    end
  end

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = fetch_pc;
  assign bus.out_valid   = head_valid;
  assign bus.out_instr1  = shown.instr1;
  assign bus.out_instr2  = shown.instr2;
  assign bus.out_pc      = shown.pc;
  assign bus.out_pc_next = pc_next;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb/tb_instruction_fetch_queue.sv - self-checking bench for instruction_fetch_queue
module tb_instruction_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_enable;
  logic        redirect_valid;
  logic [10:0] redirect_pc;

  instruction_fetch_queue_if #(.PC_WIDTH(11), .INSTR_WIDTH(32)) bus ();

  instruction_fetch_queue #(
    .PC_WIDTH    (11),
    .INSTR_WIDTH (32),
    .DEPTH       (DEPTH),
    .RESET_PC    (11'h000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_enable   (fetch_enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int consumed = 0;

  // Reference state: expected queue contents as PCs, pending fetch, next fetch PC.
  logic [10:0] mq[$];
  bit          m_inf;
  logic [10:0] m_inf_pc;
  logic [10:0] m_fpc;
  // Memory model: request seen last cycle, answered this cycle.
  bit          pend;
  logic [10:0] pend_addr;

  typedef struct {
    bit          fe;
    bit          rv;
    logic [10:0] rpc;
    bit          ordy;
    bit          exp_req;
    logic [10:0] exp_addr;
    bit          exp_valid;
    logic [10:0] exp_pc;
  } vec_t;

  vec_t vecs[20];

  function automatic logic [31:0] instr_of(input logic [10:0] a);
    return {5'h15, a, 5'h0A, a} ^ 32'h0F0F_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_inf = 1'b0;
    m_inf_pc = '0;
    m_fpc = 11'h000;
    pend = 1'b0;
    pend_addr = '0;
  endtask

  // Called just after a falling edge: drive inputs and memory data, let them settle.
  task automatic apply(input bit fe, input bit rv, input logic [10:0] rpc, input bit ordy);
    fetch_enable   = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    bus.out_ready  = ordy;
    if (pend) begin
      bus.imem_rdata1 = instr_of(pend_addr);
      bus.imem_rdata2 = instr_of(pend_addr + 11'd1);
    end else begin
      bus.imem_rdata1 = 32'hDEAD_BEEF;
      bus.imem_rdata2 = 32'hBAAD_F00D;
    end
    #1;
  endtask

  function automatic bit model_pop();
    return (mq.size() > 0) && bus.out_ready && !redirect_valid;
  endfunction

  function automatic bit model_req();
    return fetch_enable && !redirect_valid &&
           ((mq.size() + int'(m_inf) - int'(model_pop())) < DEPTH);
  endfunction

  task automatic model_check();
    logic [10:0] hp;
    logic [10:0] hn;
    bit er;
    er = model_req();
    chk("imem_req", bus.imem_req, er);
    if (er) chk("imem_addr", bus.imem_addr, m_fpc);
    chk("out_valid", bus.out_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      hp = mq[0];
      hn = hp + 11'd2;
      chk("out_pc", bus.out_pc, hp);
      chk("out_instr1", bus.out_instr1, instr_of(hp));
      chk("out_instr2", bus.out_instr2, instr_of(hp + 11'd1));
      chk("out_pc_next", bus.out_pc_next, hn);
    end
  endtask

  // Commit the model to the coming rising edge and move to the next falling edge.
  task automatic advance();
    bit pp;
    bit er;
    pp = model_pop();
    er = model_req();
    if (bus.out_valid && bus.out_ready) consumed++;
    pend = bus.imem_req;
    pend_addr = bus.imem_addr;
    if (redirect_valid) begin
      mq.delete();
      m_inf = 1'b0;
      m_fpc = redirect_pc;
    end else begin
      if (pp) void'(mq.pop_front());
      if (m_inf) mq.push_back(m_inf_pc);
      m_inf = er;
      m_inf_pc = m_fpc;
      if (er) m_fpc = m_fpc + 11'd2;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input bit fe, input bit rv, input logic [10:0] rpc, input bit ordy);
    apply(fe, rv, rpc, ordy);
    model_check();
    advance();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_imem_req"}, bus.imem_req, 1'b0);
    chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_out_pc"}, bus.out_pc, 11'h000);
    chk({tag, "_out_pc_next"}, bus.out_pc_next, 11'h000);
    chk({tag, "_out_instr1"}, bus.out_instr1, 32'h0);
    chk({tag, "_out_instr2"}, bus.out_instr2, 32'h0);
  endtask

  initial begin
    int nreq;
    int c0;

    //          fe rv  rpc     rdy req addr    vld pc
    vecs[0]  = '{1, 0, 11'h000, 1, 1, 11'h000, 0, 11'h000};
    vecs[1]  = '{1, 0, 11'h000, 1, 1, 11'h002, 0, 11'h000};
    vecs[2]  = '{1, 0, 11'h000, 1, 1, 11'h004, 1, 11'h000};
    vecs[3]  = '{1, 0, 11'h000, 1, 1, 11'h006, 1, 11'h002};
    vecs[4]  = '{1, 0, 11'h000, 1, 1, 11'h008, 1, 11'h004};
    vecs[5]  = '{1, 1, 11'h100, 1, 0, 11'h000, 1, 11'h006};
    vecs[6]  = '{1, 0, 11'h000, 1, 1, 11'h100, 0, 11'h000};
    vecs[7]  = '{1, 0, 11'h000, 1, 1, 11'h102, 0, 11'h000};
    vecs[8]  = '{1, 0, 11'h000, 1, 1, 11'h104, 1, 11'h100};
    vecs[9]  = '{1, 0, 11'h000, 1, 1, 11'h106, 1, 11'h102};
    vecs[10] = '{1, 0, 11'h000, 0, 1, 11'h108, 1, 11'h104};
    vecs[11] = '{1, 0, 11'h000, 0, 1, 11'h10A, 1, 11'h104};
    vecs[12] = '{1, 0, 11'h000, 0, 0, 11'h000, 1, 11'h104};
    vecs[13] = '{1, 0, 11'h000, 0, 0, 11'h000, 1, 11'h104};
    vecs[14] = '{1, 0, 11'h000, 1, 1, 11'h10C, 1, 11'h104};
    vecs[15] = '{0, 0, 11'h000, 1, 0, 11'h000, 1, 11'h106};
    vecs[16] = '{0, 0, 11'h000, 1, 0, 11'h000, 1, 11'h108};
    vecs[17] = '{0, 0, 11'h000, 1, 0, 11'h000, 1, 11'h10A};
    vecs[18] = '{0, 0, 11'h000, 1, 0, 11'h000, 1, 11'h10C};
    vecs[19] = '{0, 0, 11'h000, 1, 0, 11'h000, 0, 11'h000};

    reset = 1'b0;
    fetch_enable = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    bus.out_ready = 1'b1;
    bus.imem_rdata1 = '0;
    bus.imem_rdata2 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b1;

    // Directed fill, redirect over an in-flight 0x008, back-pressure, fetch disable.
    for (int i = 0; i < 20; i++) begin
      apply(vecs[i].fe, vecs[i].rv, vecs[i].rpc, vecs[i].ordy);
      chk($sformatf("vec%0d_req", i), bus.imem_req, vecs[i].exp_req);
      if (vecs[i].exp_req) chk($sformatf("vec%0d_addr", i), bus.imem_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_valid", i), bus.out_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) chk($sformatf("vec%0d_pc", i), bus.out_pc, vecs[i].exp_pc);
      model_check();
      advance();
    end

    // Empty queue, consumer stalled: exactly DEPTH requests, then none.
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      apply(1, 0, 11'h000, 0);
      if (bus.imem_req) nreq++;
      model_check();
      advance();
    end
    chk("stall_req_count", nreq, DEPTH);
    for (int i = 0; i < 8; i++) run(1, 0, 11'h000, 1);

    // Full queue: redirect together with a pop.
    for (int i = 0; i < 8; i++) run(1, 0, 11'h000, 0);
    chk("full_before_redirect", dut.count, DEPTH);
    c0 = consumed;
    run(1, 1, 11'h200, 1);
    apply(1, 0, 11'h000, 1);
    chk("redir_pop_empty", bus.out_valid, 1'b0);
    model_check();
    advance();
    chk("redir_pop_once", consumed - c0, 1);
    for (int i = 0; i < 4; i++) run(1, 0, 11'h000, 1);

    // PC wrap at the top of the address space.
    run(1, 1, 11'h7FE, 1);
    apply(1, 0, 11'h000, 1);
    chk("wrap_addr_7fe", bus.imem_addr, 11'h7FE);
    model_check();
    advance();
    apply(1, 0, 11'h000, 1);
    chk("wrap_addr_000", bus.imem_addr, 11'h000);
    model_check();
    advance();
    apply(1, 0, 11'h000, 1);
    chk("wrap_out_pc", bus.out_pc, 11'h7FE);
    chk("wrap_out_pc_next", bus.out_pc_next, 11'h000);
    chk("wrap_instr2", bus.out_instr2, instr_of(11'h7FF));
    model_check();
    advance();

    // Reset mid-operation with a partly filled queue and a request in flight.
    run(1, 0, 11'h000, 0);
    run(1, 0, 11'h000, 0);
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    reset = 1'b1;
    apply(1, 0, 11'h000, 1);
    chk("postrst_addr", bus.imem_addr, 11'h000);
    chk("postrst_req", bus.imem_req, 1'b1);
    model_check();
    advance();
    run(1, 0, 11'h000, 1);
    apply(1, 0, 11'h000, 1);
    chk("postrst_first_pc", bus.out_pc, 11'h000);
    model_check();
    advance();

    // Randomised traffic against the reference queue.
    for (int i = 0; i < 400; i++) begin
      run(($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0),
          11'($urandom), ($urandom_range(0, 9) < 7));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
